// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks FIRST_REG..LAST_REG on a spare read port and
// streams each snapshotted word (optionally preceded by an address header) as bytes.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int HEADER_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [4:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_HDR, S_BYTE, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_abort_pend;
  logic [4:0]  r_rd_addr;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_xfer;
  logic        w_abort;

  assign w_xfer  = r_tx_valid && tx_ready_i;
  // An abort seen on the same edge as a transfer still lets that byte finish.
  assign w_abort = abort_i || r_abort_pend;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_cnt        <= '0;
      r_abort_pend <= 1'b0;
      r_rd_addr    <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_CAPTURE;
            r_rd_addr <= 5'(FIRST_REG);
            r_busy    <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (abort_i) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
          end else begin
            r_word     <= rd_data_i;
            r_cnt      <= 2'd0;
            r_tx_valid <= 1'b1;
            if (HEADER_EN != 0) begin
              r_state   <= S_HDR;
              r_tx_data <= {3'b000, r_rd_addr};
            end else begin
              r_state   <= S_BYTE;
              r_tx_data <= rd_data_i[31:24];
            end
          end
        end
        S_HDR: begin
          if (abort_i) r_abort_pend <= 1'b1;
          if (w_xfer) begin
            if (w_abort) begin
              r_state      <= S_IDLE;
              r_tx_valid   <= 1'b0;
              r_busy       <= 1'b0;
              r_abort_pend <= 1'b0;
            end else begin
              r_state   <= S_BYTE;
              r_cnt     <= 2'd0;
              r_tx_data <= r_word[31:24];
            end
          end
        end
        S_BYTE: begin
          if (abort_i) r_abort_pend <= 1'b1;
          if (w_xfer) begin
            if (w_abort) begin
              r_state      <= S_IDLE;
              r_tx_valid   <= 1'b0;
              r_busy       <= 1'b0;
              r_abort_pend <= 1'b0;
            end else if (r_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              if (r_rd_addr == 5'(LAST_REG)) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_CAPTURE;
                r_rd_addr <= r_rd_addr + 5'd1;
              end
            end else begin
              r_cnt     <= r_cnt + 2'd1;
              r_tx_data <= sel_byte(r_word, r_cnt + 2'd1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr_o  = r_rd_addr;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: scoreboard of expected bytes built from a register
// array model, popped by a monitor on every valid/ready handshake.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];

  logic        a_start, a_abort, a_ready, a_valid, a_busy, a_done;
  logic [4:0]  a_addr;
  logic [31:0] a_rdata;
  logic [7:0]  a_data;

  logic        b_start, b_abort, b_ready, b_valid, b_busy, b_done;
  logic [4:0]  b_addr;
  logic [31:0] b_rdata;
  logic [7:0]  b_data;

  assign a_rdata = regs[a_addr];
  assign b_rdata = regs[b_addr];

  regfile_dump_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .abort_i(a_abort),
    .rd_addr_o(a_addr), .rd_data_i(a_rdata), .tx_data_o(a_data),
    .tx_valid_o(a_valid), .tx_ready_i(a_ready), .busy_o(a_busy), .done_o(a_done)
  );

  regfile_dump_reader #(.FIRST_REG(7), .LAST_REG(7), .HEADER_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort),
    .rd_addr_o(b_addr), .rd_data_i(b_rdata), .tx_data_o(b_data),
    .tx_valid_o(b_valid), .tx_ready_i(b_ready), .busy_o(b_busy), .done_o(b_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  logic [7:0] a_q [$];
  logic [7:0] b_q [$];
  bit a_hold = 1'b0, b_hold = 1'b0;
  logic [7:0] a_hold_data = '0, b_hold_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start must be raised just after an edge; k is the edge that samples it.
  task automatic pulse_start(input bit use_b, output int k);
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input bit use_b, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((use_b ? b_done : a_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Reference: header (address) then the word MSB first, for every register.
  task automatic push_regs(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      a_q.push_back(8'(r));
      for (int b = 3; b >= 0; b--) a_q.push_back(regs[r][8*b +: 8]);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
  endtask

  initial begin
    int k, at;
    bit found, bad_done, bad_valid;
    a_start = 0; a_abort = 0; a_ready = 1;
    b_start = 0; b_abort = 0; b_ready = 1;
    load_ramp();

    fork
      forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ready) a_ready = ($urandom_range(0, 99) < 40);
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (a_hold) begin
            chk("a_stall_valid", int'(a_valid), 1);
            chk("a_stall_data", int'(a_data), int'(a_hold_data));
          end
          if (a_valid && a_ready) begin
            if (a_q.size() == 0) chk("a_extra_byte", int'(a_data), -1);
            else chk("a_byte", int'(a_data), int'(a_q.pop_front()));
          end
          if (b_hold) begin
            chk("b_stall_valid", int'(b_valid), 1);
            chk("b_stall_data", int'(b_data), int'(b_hold_data));
          end
          if (b_valid && b_ready) begin
            if (b_q.size() == 0) chk("b_extra_byte", int'(b_data), -1);
            else chk("b_byte", int'(b_data), int'(b_q.pop_front()));
          end
        end
        a_hold = rst_n && a_valid && !a_ready;
        a_hold_data = a_data;
        b_hold = rst_n && b_valid && !b_ready;
        b_hold_data = b_data;
      end
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_data", int'(a_data), 0);
    chk("rst_b_addr", int'(b_addr), 0);
    rst_n = 1'b1;
    tick();

    // Full dump, ready always high
    push_regs(0, 31);
    pulse_start(1'b0, k);
    chk("t1_capture_busy", int'(a_busy), 1);
    chk("t1_capture_valid", int'(a_valid), 0);
    chk("t1_capture_addr", int'(a_addr), 0);
    tick();
    chk("t1_first_valid", int'(a_valid), 1);
    chk("t1_first_data", int'(a_data), 0);
    wait_done(1'b0, 400, at);
    chk("t1_done_cycle", at, k + 192);
    chk("t1_busy_at_done", int'(a_busy), 0);
    @(negedge clk);
    chk("t1_done_single", int'(a_done), 0);
    chk("t1_busy_after", int'(a_busy), 0);
    chk("t1_queue_empty", a_q.size(), 0);
    tick();

    // Random register contents, random backpressure
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rand_ready = 1'b1;
    push_regs(0, 31);
    pulse_start(1'b0, k);
    wait_done(1'b0, 2000, at);
    chk("t2_done_seen", int'(at != -1), 1);
    rand_ready = 1'b0;
    tick();
    a_ready = 1'b1;
    chk("t2_queue_empty", a_q.size(), 0);
    tick();

    // Snapshot: rewrite reg 5 while 0xAD is stalled; also a stray start mid-dump
    load_ramp();
    regs[5] = 32'hDEADBEEF;
    push_regs(0, 31);
    pulse_start(1'b0, k);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (a_valid && a_addr == 5'd5 && a_data == 8'hAD) found = 1'b1;
    end
    chk("t3_found_ad", int'(found), 1);
    a_ready = 1'b0;
    regs[5] = 32'h12345678;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("t3_busy_stalled", int'(a_busy), 1);
    a_ready = 1'b1;
    wait_done(1'b0, 400, at);
    chk("t3_done_seen", int'(at != -1), 1);
    chk("t3_queue_empty", a_q.size(), 0);
    tick();
    tick();

    // Abort while header 0x03 is stalled
    load_ramp();
    push_regs(0, 2);
    a_q.push_back(8'h03);
    pulse_start(1'b0, k);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (a_valid && a_addr == 5'd3 && a_data == 8'h03) found = 1'b1;
    end
    chk("t4_found_hdr", int'(found), 1);
    a_ready = 1'b0;
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    tick();
    tick();
    chk("t4_hold_valid", int'(a_valid), 1);
    chk("t4_hold_data", int'(a_data), 3);
    chk("t4_hold_busy", int'(a_busy), 1);
    a_ready = 1'b1;
    tick();
    chk("t4_idle_valid", int'(a_valid), 0);
    chk("t4_idle_busy", int'(a_busy), 0);
    chk("t4_addr_kept", int'(a_addr), 3);
    bad_done = 1'b0;
    bad_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_done !== 1'b0) bad_done = 1'b1;
      if (a_valid !== 1'b0) bad_valid = 1'b1;
    end
    chk("t4_no_done", int'(bad_done), 0);
    chk("t4_no_more_bytes", int'(bad_valid), 0);
    chk("t4_queue_empty", a_q.size(), 0);
    tick();

    // Reset mid-dump, then a complete dump from FIRST_REG
    push_regs(0, 31);
    pulse_start(1'b0, k);
    repeat (20) tick();
    chk("t5_busy_before", int'(a_busy), 1);
    rst_n = 1'b0;
    a_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_valid", int'(a_valid), 0);
    chk("t5_rst_busy", int'(a_busy), 0);
    chk("t5_rst_addr", int'(a_addr), 0);
    chk("t5_rst_done", int'(a_done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_regs(0, 31);
    tick();
    pulse_start(1'b0, k);
    wait_done(1'b0, 400, at);
    chk("t5_done_cycle", at, k + 192);
    chk("t5_queue_empty", a_q.size(), 0);
    tick();

    // Single register, no header
    regs[7] = 32'hA5A50F0F;
    b_q.push_back(8'hA5);
    b_q.push_back(8'hA5);
    b_q.push_back(8'h0F);
    b_q.push_back(8'h0F);
    pulse_start(1'b1, k);
    chk("t6_addr_start", int'(b_addr), 7);
    chk("t6_busy", int'(b_busy), 1);
    wait_done(1'b1, 20, at);
    chk("t6_done_cycle", at, k + 5);
    chk("t6_addr_at_done", int'(b_addr), 7);
    @(negedge clk);
    chk("t6_done_single", int'(b_done), 0);
    chk("t6_busy_after", int'(b_busy), 0);
    chk("t6_addr_after", int'(b_addr), 7);
    chk("t6_queue_empty", b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
